// File: rtl/segmented_multichannel_accumulator.sv
// ---------------------------------------------------------------------------
// segmented_multichannel_accumulator
//
// Multichannel signed accumulator with a skewed, segmented carry chain.
// The DATA_W-bit addition is split into NSEG = DATA_W/SEG_W segments. Stage k
// adds segment k of an operation exactly k cycles after the operation is
// accepted, so no carry chain is longer than SEG_W bits. Each of the CHANNELS
// channels has its own accumulator and sticky overflow flag. Operations on
// any channel can be interleaved cycle by cycle, including back-to-back on
// the same channel.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand present this cycle (no backpressure)
//   in_data    signed operand, DATA_W bits
//   in_ch      target channel; values >= CHANNELS are dropped
//   in_first   load in_data instead of adding; clears the channel's overflow
//   in_last    emit the channel's result once this term is complete
//   out_valid  one-cycle result pulse, NSEG cycles after the accepting edge
//   out_data   assembled accumulator value including the last term
//   out_ch     channel of the result
//   out_ovf    sticky signed overflow since the channel's last in_first
// out_data/out_ch/out_ovf hold their values while out_valid is low.
// ---------------------------------------------------------------------------
module segmented_multichannel_accumulator #(
    parameter int unsigned DATA_W   = 28,
    parameter int unsigned SEG_W    = 14,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_ovf
);

    localparam int NSEG  = int'(DATA_W / SEG_W);
    localparam int TOP   = NSEG - 1;
    localparam int NPIPE = (NSEG > 1) ? NSEG - 1 : 1;

    if (((DATA_W % SEG_W) != 0) || (NSEG < 1) || (SEG_W < 2)) begin : g_param_check
        $error("DATA_W must be a non-zero integer multiple of SEG_W, with SEG_W >= 2");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [SEG_W-1:0]  acc_q [CHANNELS][NSEG];
    logic [SEG_W-1:0]  acc_d [CHANNELS][NSEG];
    logic [CHANNELS-1:0] ovf_q, ovf_d;

    // Skew registers: entry j carries an operation from stage j to stage j+1.
    // The word holds finished result segments below j+1 and still-unused
    // operand segments from j+1 upwards.
    logic [NPIPE-1:0]  pipe_valid_q, pipe_valid_d;
    logic [NPIPE-1:0]  pipe_first_q, pipe_first_d;
    logic [NPIPE-1:0]  pipe_last_q,  pipe_last_d;
    logic [NPIPE-1:0]  pipe_carry_q, pipe_carry_d;
    logic [CH_W-1:0]   pipe_ch_q   [NPIPE];
    logic [CH_W-1:0]   pipe_ch_d   [NPIPE];
    logic [DATA_W-1:0] pipe_word_q [NPIPE];
    logic [DATA_W-1:0] pipe_word_d [NPIPE];

    // Operation that just left the top stage; only last-tagged ones are valid.
    logic              top_valid_q, top_valid_d;
    logic [DATA_W-1:0] top_word_q,  top_word_d;
    logic [CH_W-1:0]   top_ch_q,    top_ch_d;
    logic              top_ovf_q,   top_ovf_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;
    logic              out_ovf_q,   out_ovf_d;

    // -----------------------------------------------------------------------
    // Stage inputs
    // -----------------------------------------------------------------------
    logic              ch_ok;
    logic [NSEG-1:0]   st_valid, st_first, st_last, st_cin;
    logic [CH_W-1:0]   st_ch   [NSEG];
    logic [DATA_W-1:0] st_word [NSEG];

    assign ch_ok = (32'(in_ch) < CHANNELS);

    for (genvar k = 0; k < NSEG; k++) begin : g_stage_in
        if (k == 0) begin : g_head
            assign st_valid[k] = in_valid & ch_ok;
            // Out-of-range channels are dropped; keep the index in range.
            assign st_ch[k]    = ch_ok ? in_ch : '0;
            assign st_first[k] = in_first;
            assign st_last[k]  = in_last;
            assign st_word[k]  = in_data;
            assign st_cin[k]   = 1'b0;
        end else begin : g_skew
            assign st_valid[k] = pipe_valid_q[k-1];
            assign st_ch[k]    = pipe_ch_q[k-1];
            assign st_first[k] = pipe_first_q[k-1];
            assign st_last[k]  = pipe_last_q[k-1];
            assign st_word[k]  = pipe_word_q[k-1];
            assign st_cin[k]   = pipe_carry_q[k-1];
        end
    end

    // -----------------------------------------------------------------------
    // Segment arithmetic
    // -----------------------------------------------------------------------
    logic [SEG_W-1:0]  op_seg   [NSEG];
    logic [SEG_W-1:0]  acc_seg  [NSEG];
    logic [SEG_W:0]    sum      [NSEG];
    logic [DATA_W-1:0] res_word [NSEG];
    logic [NSEG-1:0]   cout;

    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            op_seg[k]  = st_word[k][k*SEG_W +: SEG_W];
            // first masks the accumulator only; the carry still propagates.
            acc_seg[k] = st_first[k] ? '0 : acc_q[st_ch[k]][k];
            sum[k]     = {1'b0, op_seg[k]} + {1'b0, acc_seg[k]} + {{SEG_W{1'b0}}, st_cin[k]};
            cout[k]    = sum[k][SEG_W];
            res_word[k] = st_word[k];
            res_word[k][k*SEG_W +: SEG_W] = sum[k][SEG_W-1:0];
        end
    end

    // Carry into the sign bit is recovered from the sum bit: s = a ^ b ^ c.
    logic sign_cin, top_ovfl, top_ovf_new;

    assign sign_cin    = sum[TOP][SEG_W-1] ^ op_seg[TOP][SEG_W-1] ^ acc_seg[TOP][SEG_W-1];
    assign top_ovfl    = sign_cin ^ cout[TOP];
    assign top_ovf_new = (st_first[TOP] ? 1'b0 : ovf_q[st_ch[TOP]]) | top_ovfl;

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;

        // Each stage owns a distinct segment, so the writes never collide.
        for (int k = 0; k < NSEG; k++) begin
            if (st_valid[k]) begin
                acc_d[st_ch[k]][k] = sum[k][SEG_W-1:0];
            end
        end
        if (st_valid[TOP]) begin
            ovf_d[st_ch[TOP]] = top_ovf_new;
        end

        pipe_valid_d = '0;
        pipe_first_d = '0;
        pipe_last_d  = '0;
        pipe_carry_d = '0;
        for (int j = 0; j < NPIPE; j++) begin
            pipe_ch_d[j]   = '0;
            pipe_word_d[j] = '0;
        end
        for (int j = 0; j < NSEG - 1; j++) begin
            pipe_valid_d[j] = st_valid[j];
            pipe_first_d[j] = st_first[j];
            pipe_last_d[j]  = st_last[j];
            pipe_carry_d[j] = cout[j];
            pipe_ch_d[j]    = st_ch[j];
            pipe_word_d[j]  = res_word[j];
        end

        // Lower result segments travel with the operation, so a later term
        // on the same channel cannot disturb this result.
        top_valid_d = st_valid[TOP] & st_last[TOP];
        top_word_d  = res_word[TOP];
        top_ch_d    = st_ch[TOP];
        top_ovf_d   = top_ovf_new;

        out_valid_d = top_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_ovf_d   = out_ovf_q;
        if (top_valid_q) begin
            out_data_d = top_word_q;
            out_ch_d   = top_ch_q;
            out_ovf_d  = top_ovf_q;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int s = 0; s < NSEG; s++) begin
                    acc_q[c][s] <= '0;
                end
            end
            ovf_q        <= '0;
            pipe_valid_q <= '0;
            pipe_first_q <= '0;
            pipe_last_q  <= '0;
            pipe_carry_q <= '0;
            for (int j = 0; j < NPIPE; j++) begin
                pipe_ch_q[j]   <= '0;
                pipe_word_q[j] <= '0;
            end
            top_valid_q <= 1'b0;
            top_word_q  <= '0;
            top_ch_q    <= '0;
            top_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_first_q <= pipe_first_d;
            pipe_last_q  <= pipe_last_d;
            pipe_carry_q <= pipe_carry_d;
            pipe_ch_q    <= pipe_ch_d;
            pipe_word_q  <= pipe_word_d;
            top_valid_q  <= top_valid_d;
            top_word_q   <= top_word_d;
            top_ch_q     <= top_ch_d;
            top_ovf_q    <= top_ovf_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_segmented_multichannel_accumulator.sv
// ---------------------------------------------------------------------------
// Testbench for segmented_multichannel_accumulator.
// A channel-level arithmetic model predicts every output cycle; directed
// sequences add literal expectations for each emitted result.
// ---------------------------------------------------------------------------
module tb_segmented_multichannel_accumulator;

    localparam int DATA_W   = 28;
    localparam int SEG_W    = 14;
    localparam int CHANNELS = 4;
    localparam int NSEG     = DATA_W / SEG_W;
    localparam int CH_W     = 2;
    localparam longint MAXV = (64'sd1 <<< (DATA_W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (DATA_W - 1));

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   in_ch;
    logic              in_first;
    logic              in_last;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_ovf;

    always #5 clk = ~clk;

    segmented_multichannel_accumulator #(
        .DATA_W   (DATA_W),
        .SEG_W    (SEG_W),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   ch;
        logic              ovf;
    } res_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit model_live = 1'b0;

    logic signed [DATA_W-1:0] acc_m [CHANNELS];
    logic                     ovf_m [CHANNELS];
    res_t pend_q[$];
    res_t obs_q[$];
    res_t mr;
    longint msum;

    logic              exp_valid = 1'b0;
    logic [DATA_W-1:0] exp_data  = '0;
    logic [CH_W-1:0]   exp_ch    = '0;
    logic              exp_ovf   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Channel-level model: sequential per-channel arithmetic, result due
    // NSEG edges after the accepting edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    acc_m[c] = '0;
                    ovf_m[c] = 1'b0;
                end
                pend_q.delete();
                exp_valid  = 1'b0;
                exp_data   = '0;
                exp_ch     = '0;
                exp_ovf    = 1'b0;
                model_live = 1'b1;
            end else begin
                exp_valid = 1'b0;
                if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                    mr        = pend_q.pop_front();
                    exp_valid = 1'b1;
                    exp_data  = mr.data;
                    exp_ch    = mr.ch;
                    exp_ovf   = mr.ovf;
                end
                if (in_valid && int'(in_ch) < CHANNELS) begin
                    if (in_first) begin
                        acc_m[in_ch] = in_data;
                        ovf_m[in_ch] = 1'b0;
                    end else begin
                        msum = longint'(acc_m[in_ch]) + longint'($signed(in_data));
                        if (msum > MAXV || msum < MINV) ovf_m[in_ch] = 1'b1;
                        acc_m[in_ch] = msum[DATA_W-1:0];
                    end
                    if (in_last) begin
                        mr.due  = cyc + NSEG;
                        mr.data = acc_m[in_ch];
                        mr.ch   = in_ch;
                        mr.ovf  = ovf_m[in_ch];
                        pend_q.push_back(mr);
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                chk("out_valid", 64'(out_valid), 64'(exp_valid));
                chk("out_data",  64'(out_data),  64'(exp_data));
                chk("out_ch",    64'(out_ch),    64'(exp_ch));
                chk("out_ovf",   64'(out_ovf),   64'(exp_ovf));
                if (out_valid === 1'b1) begin
                    mr.due  = cyc;
                    mr.data = out_data;
                    mr.ch   = out_ch;
                    mr.ovf  = out_ovf;
                    obs_q.push_back(mr);
                end
            end
        end
    end

    task automatic send(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d,
                        input logic f, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        in_first = f;
        in_last  = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic expect_res(input string name, input logic [DATA_W-1:0] d,
                              input logic [CH_W-1:0] ch, input logic ovf);
        res_t r;
        int   waited = 0;
        while (obs_q.size() == 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        chk({name, " present"}, 64'(obs_q.size() > 0), 64'd1);
        if (obs_q.size() > 0) begin
            r = obs_q.pop_front();
            chk({name, " data"}, 64'(r.data), 64'(d));
            chk({name, " ch"},   64'(r.ch),   64'(ch));
            chk({name, " ovf"},  64'(r.ovf),  64'(ovf));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        in_ch    = '0;
        in_data  = 28'h0000123;
        in_first = 1'b1;
        in_last  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data",  64'(out_data),  64'd0);
        chk("reset out_ovf",   64'(out_ovf),   64'd0);
        chk("reset out_ch",    64'(out_ch),    64'd0);

        // Accumulation after reset starts from zero.
        send(0, 28'h0000010, 1'b0, 1'b1);
        idle(1);
        expect_res("post-reset", 28'h0000010, 0, 1'b0);

        // Carry out of segment 0 into segment 1.
        send(0, 28'h0003FFF, 1'b1, 1'b0);
        send(0, 28'h0000001, 1'b0, 1'b1);
        idle(1);
        expect_res("carry", 28'h0004000, 0, 1'b0);

        // Negative operands.
        send(2, 28'hFFFFFFB, 1'b1, 1'b0);
        send(2, 28'h0000002, 1'b0, 1'b0);
        send(2, 28'h0000002, 1'b0, 1'b1);
        idle(1);
        expect_res("negative", 28'hFFFFFFF, 2, 1'b0);

        // Back-to-back on one channel.
        for (int i = 1; i <= 8; i++) send(1, DATA_W'(i), i == 1, i == 8);
        idle(1);
        expect_res("b2b ch1", 28'd36, 1, 1'b0);

        // Persistence after last.
        send(1, 28'd4, 1'b0, 1'b1);
        idle(1);
        expect_res("persist ch1", 28'd40, 1, 1'b0);

        // Interleaved channels.
        for (int i = 1; i <= 8; i++) begin
            send((i % 2 == 1) ? 2'd0 : 2'd3, DATA_W'(i), i <= 2, i >= 7);
        end
        idle(1);
        expect_res("interleave ch0", 28'd16, 0, 1'b0);
        expect_res("interleave ch3", 28'd20, 3, 1'b0);

        // Positive overflow, then first clears the flag.
        send(0, 28'h7FFFFFF, 1'b1, 1'b0);
        send(0, 28'h0000001, 1'b0, 1'b1);
        idle(1);
        expect_res("pos ovf", 28'h8000000, 0, 1'b1);
        send(0, 28'd5, 1'b1, 1'b1);
        idle(1);
        expect_res("first|last", 28'd5, 0, 1'b0);

        // Negative overflow and sticky flag without first.
        send(3, 28'h8000000, 1'b1, 1'b0);
        send(3, 28'hFFFFFFF, 1'b0, 1'b1);
        idle(1);
        expect_res("neg ovf", 28'h7FFFFFF, 3, 1'b1);
        send(3, 28'd0, 1'b0, 1'b1);
        idle(1);
        expect_res("sticky ovf", 28'h7FFFFFF, 3, 1'b1);

        // Reset while an operation is in flight.
        idle(2);
        send(0, 28'd7, 1'b1, 1'b1);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        chk("no out after mid reset", 64'(obs_q.size()), 64'd0);
        send(0, 28'd1, 1'b0, 1'b1);
        idle(1);
        expect_res("after mid reset", 28'd1, 0, 1'b0);

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
